// File: rtl/fetch_unit.sv
// fetch_unit: program counter, ROM fetch control, redirect squash and delivered-instruction count
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump_valid,
  input  logic [31:0]          jump_target,
  output logic [31:0]          rom_addr,
  output logic                 rom_stall,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_pc_plus4,
  output logic                 if_valid,
  output logic                 addr_error,
  output logic [CNT_WIDTH-1:0] fetch_count
);
  logic redirect;
  logic [31:0] target;
  logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d;
  logic if_valid_q, if_valid_d, addr_error_q, addr_error_d;
  logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
  assign redirect = branch_taken | jump_valid;
  assign target = branch_taken ? branch_target : jump_target;
  assign rom_stall = stall_in & ~redirect;
  assign rom_addr = pc_q;
  assign if_pc = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign if_valid = if_valid_q;
  assign addr_error = addr_error_q;
  assign fetch_count = fetch_count_q;
  // redirect beats stall; a redirect squashes the word already in flight in the ROM
  always_comb begin
    pc_d = redirect ? {target[31:2], 2'b00} : rom_stall ? pc_q : pc_q + 32'd4;
    if_pc_d = rom_stall ? if_pc_q : pc_q;
    if_valid_d = ~redirect & (~stall_in | if_valid_q);
    addr_error_d = redirect & (|target[1:0]);
    fetch_count_d = fetch_count_q + CNT_WIDTH'(if_valid_q & ~stall_in & ~redirect);
  end
  // fetch state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      if_pc_q <= '0;
      if_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q <= pc_d;
      if_pc_q <= if_pc_d;
      if_valid_q <= if_valid_d;
      addr_error_q <= addr_error_d;
      fetch_count_q <= fetch_count_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset, stall_in, branch_taken, jump_valid;
  logic [31:0] branch_target, jump_target;
  logic [31:0] rom_addr, if_pc, if_pc_plus4, fetch_count;
  logic rom_stall, if_valid, addr_error;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string tag;
    logic [31:0] addr, pc, cnt;
    logic v, ae;
  } exp_t;
  exp_t sb[$];
  always #5 clock = ~clock;
  fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .stall_in(stall_in),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump_valid(jump_valid),
    .jump_target(jump_target),
    .rom_addr(rom_addr),
    .rom_stall(rom_stall),
    .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4),
    .if_valid(if_valid),
    .addr_error(addr_error),
    .fetch_count(fetch_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic st, input logic br,
                      input logic [31:0] bt, input logic jv, input logic [31:0] jt,
                      input logic es, input logic [31:0] ea, input logic [31:0] ep,
                      input logic ev, input logic eae, input logic [31:0] ec);
    exp_t e;
    reset = r;
    stall_in = st;
    branch_taken = br;
    branch_target = bt;
    jump_valid = jv;
    jump_target = jt;
    #1;
    chk({tag, ":rom_stall"}, 32'(rom_stall), 32'(es));
    e.tag = tag;
    e.addr = ea;
    e.pc = ep;
    e.cnt = ec;
    e.v = ev;
    e.ae = eae;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({e.tag, ":rom_addr"}, rom_addr, e.addr);
    chk({e.tag, ":if_pc"}, if_pc, e.pc);
    chk({e.tag, ":if_pc_plus4"}, if_pc_plus4, e.pc + 32'd4);
    chk({e.tag, ":if_valid"}, 32'(if_valid), 32'(e.v));
    chk({e.tag, ":addr_error"}, 32'(addr_error), 32'(e.ae));
    chk({e.tag, ":fetch_count"}, fetch_count, e.cnt);
  endtask
  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step("seq1", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, 0, 0);
    step("seq2", 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, 1, 0, 1);
    step("seq3", 0, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 1, 0, 2);
    step("seq4", 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, 1, 0, 3);
    step("seq5", 0, 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, 1, 0, 4);
    step("rst2", 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step("run1", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, 0, 0);
    step("run2", 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, 1, 0, 1);
    step("stall1", 0, 1, 0, 0, 0, 0, 1, 32'h8, 32'h4, 1, 0, 1);
    step("stall2", 0, 1, 0, 0, 0, 0, 1, 32'h8, 32'h4, 1, 0, 1);
    step("stall3", 0, 1, 0, 0, 0, 0, 1, 32'h8, 32'h4, 1, 0, 1);
    step("release", 0, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, 1, 0, 2);
    step("run3", 0, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, 1, 0, 3);
    step("branch", 0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 32'h10, 0, 0, 3);
    step("br_tgt", 0, 0, 0, 0, 0, 0, 0, 32'h44, 32'h40, 1, 0, 3);
    step("br_next", 0, 0, 0, 0, 0, 0, 0, 32'h48, 32'h44, 1, 0, 4);
    step("prio", 0, 1, 1, 32'h80, 1, 32'h100, 0, 32'h80, 32'h48, 0, 0, 4);
    step("prio_stall", 0, 1, 0, 0, 0, 0, 1, 32'h80, 32'h48, 0, 0, 4);
    step("prio_tgt", 0, 0, 0, 0, 0, 0, 0, 32'h84, 32'h80, 1, 0, 4);
    step("prio_next", 0, 0, 0, 0, 0, 0, 0, 32'h88, 32'h84, 1, 0, 5);
    step("misalign", 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 32'h88, 0, 1, 5);
    step("wrap", 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 5);
    step("after_wrap", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, 0, 6);
    for (int i = 0; i < 8; i++)
      step("walk", 0, 0, 0, 0, 0, 0, 0, 32'(8 + 4 * i), 32'(4 + 4 * i), 1, 0, 32'(7 + i));
    step("rst_mid", 1, 1, 1, 32'h200, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
